// File: rtl/ascon_decrypt_top_pkg.sv
// ascon_decrypt_top_pkg: shared ASCON-128 constants, state/FSM types and the single-round permutation.
package ascon_decrypt_top_pkg;
  localparam logic [63:0] IV = 64'h80400C0600000000;
  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, PERM_AD, WAIT_CT, PERM_CT, FINAL, DONE
  } dec_state_t;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One round indexed by r (0..11): constant addition, bitsliced S-box, linear layer.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s.x0 ^ s.x4;
    x1 = s.x1;
    x2 = s.x2 ^ {56'd0, ~r, r} ^ s.x1;
    x3 = s.x3;
    x4 = s.x4 ^ s.x3;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return '{x0: x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
             x1: x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
             x2: x2 ^ ror64(x2, 1) ^ ror64(x2, 6),
             x3: x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
             x4: x4 ^ ror64(x4, 7) ^ ror64(x4, 41)};
  endfunction
endpackage

// File: rtl/ascon_dec_fsm.sv
// ascon_dec_fsm: phase sequencing, round and block counters, datapath strobes for the ASCON-128 decryptor.
module ascon_dec_fsm import ascon_decrypt_top_pkg::*; #(
  parameter int NB_CT = 3
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output dec_state_t o_state,
  output logic [3:0] o_rnd,
  output logic       o_load,
  output logic       o_ad,
  output logic       o_ct,
  output logic       o_last,
  output logic       o_rlast,
  output logic       o_busy,
  output logic       o_end
);
  dec_state_t r_state;
  logic [3:0] r_rnd, r_blk;
  logic r_busy, r_end;

  assign o_state = r_state;
  assign o_rnd   = r_rnd;
  assign o_busy  = r_busy;
  assign o_end   = r_end;
  assign o_load  = (r_state == IDLE || r_state == DONE) && start_i;
  assign o_ad    = r_state == WAIT_AD && data_valid_i;
  assign o_ct    = r_state == WAIT_CT && data_valid_i;
  assign o_last  = r_blk == 4'(NB_CT - 1);
  assign o_rlast = r_rnd == 4'd11;

  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      r_state <= IDLE;
      r_rnd   <= '0;
      r_blk   <= '0;
      r_busy  <= 1'b0;
      r_end   <= 1'b0;
    end else if (o_load) begin
      r_state <= INIT;
      r_rnd   <= 4'(12 - ROUNDS_A);
      r_blk   <= '0;
      r_busy  <= 1'b1;
      r_end   <= 1'b0;
    end else
      case (r_state)
        INIT, PERM_AD, PERM_CT, FINAL: begin
          r_rnd <= o_rlast ? 4'd0 : r_rnd + 4'd1;
          if (o_rlast) r_state <= r_state == INIT ? WAIT_AD : r_state == FINAL ? DONE : WAIT_CT;
          if (o_rlast && r_state == FINAL) begin
            r_busy <= 1'b0;
            r_end  <= 1'b1;
          end
        end
        WAIT_AD: if (data_valid_i) begin
          r_state <= PERM_AD;
          r_rnd   <= 4'(12 - ROUNDS_B);
        end
        WAIT_CT: if (data_valid_i) begin
          r_blk   <= r_blk + 4'd1;
          r_state <= o_last ? FINAL : PERM_CT;
          r_rnd   <= o_last ? 4'(12 - ROUNDS_A) : 4'(12 - ROUNDS_B);
        end
        default: ;
      endcase
endmodule

// File: rtl/ascon_decrypt_top.sv
// ascon_decrypt_top: ASCON-128 decryption, one permutation round per clock.
// Optional ASCON_DEC_TAG_CHECK_EN builds the tag comparator driving tag_ok_o.
module ascon_decrypt_top import ascon_decrypt_top_pkg::*; #(
  parameter int NB_CT = 3
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  input  logic [127:0] tag_i,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic [127:0] tag_o,
  output logic         tag_ok_o,
  output logic         end_o,
  output logic         busy_o
);
  dec_state_t w_state;
  logic [3:0] w_rnd;
  logic w_load, w_ad, w_ct, w_last, w_rlast, w_perm, w_fin;
  ascon_state_t r_s, w_r, w_post;
  logic [127:0] w_tag, r_tag;
  logic [63:0] r_plain;
  logic r_pv;

  ascon_dec_fsm #(.NB_CT(NB_CT)) u_fsm (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .o_state(w_state), .o_rnd(w_rnd), .o_load(w_load), .o_ad(w_ad), .o_ct(w_ct),
    .o_last(w_last), .o_rlast(w_rlast), .o_busy(busy_o), .o_end(end_o)
  );

  assign w_r    = ascon_round(r_s, w_rnd);
  assign w_perm = w_state inside {INIT, PERM_AD, PERM_CT, FINAL};
  assign w_fin  = w_rlast && w_state == FINAL;
  // Key feed-forward closes INIT; the trailing 1 separates AD from ciphertext.
  assign w_post = w_r ^ {192'd0, (w_rlast && w_state == INIT) ? key_i : 128'd0}
                      ^ {319'd0, w_rlast && w_state == PERM_AD};
  assign w_tag  = {w_r.x3, w_r.x4} ^ key_i;

  assign plain_o       = r_plain;
  assign plain_valid_o = r_pv;
  assign tag_o         = r_tag;

  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      r_s     <= '0;
      r_plain <= '0;
      r_pv    <= 1'b0;
      r_tag   <= '0;
    end else begin
      r_pv <= w_ct;
      if (w_ct) r_plain <= r_s.x0 ^ data_i;
      if (w_fin) r_tag <= w_tag;
      if (w_load) r_s <= {IV, key_i, nonce_i};
      else if (w_ad) r_s.x0 <= r_s.x0 ^ data_i;
      else if (w_ct) r_s <= {data_i, r_s.x1 ^ (w_last ? key_i[127:64] : 64'd0),
                             r_s.x2 ^ (w_last ? key_i[63:0] : 64'd0), r_s.x3, r_s.x4};
      else if (w_perm) r_s <= w_post;
    end

`ifdef ASCON_DEC_TAG_CHECK_EN
  logic [127:0] r_tag_exp;
  logic r_tag_ok;
  assign tag_ok_o = r_tag_ok;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      r_tag_exp <= '0;
      r_tag_ok  <= 1'b0;
    end else begin
      if (w_ct && w_last) r_tag_exp <= tag_i;
      if (w_load) r_tag_ok <= 1'b0;
      else if (w_fin) r_tag_ok <= ~|(w_tag ^ r_tag_exp);
    end
`else
  logic w_unused_tag;
  assign w_unused_tag = ^tag_i;
  assign tag_ok_o     = 1'b0;
`endif
endmodule

// File: tb/tb_ascon_decrypt_top.sv
// tb_ascon_decrypt_top: directed/randomized checks of ascon_decrypt_top against a table-driven
// ASCON-128 message-level model (encrypt to make ciphertext, decrypt to predict outputs).
module tb_ascon_decrypt_top;
  localparam int NB = 3;
  localparam logic [63:0] IV = 64'h80400C0600000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
`ifdef ASCON_DEC_TAG_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  logic clock_i = 1'b0, resetb_i = 1'b0, start_i = 1'b0, data_valid_i = 1'b0;
  logic [127:0] key_i = '0, nonce_i = '0, tag_i = '0;
  logic [63:0] data_i = '0;
  logic [63:0] plain_o;
  logic plain_valid_o, tag_ok_o, end_o, busy_o;
  logic [127:0] tag_o;

  ascon_decrypt_top #(.NB_CT(NB)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .key_i(key_i), .nonce_i(nonce_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .tag_i(tag_i), .plain_o(plain_o),
    .plain_valid_o(plain_valid_o), .tag_o(tag_o), .tag_ok_o(tag_ok_o), .end_o(end_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int n_tests = 0, n_fail = 0, base = 0;
  logic [63:0] pq[$];
  always @(negedge clock_i) if (plain_valid_o) pq.push_back(plain_o);

  logic [63:0] m_x [5];
  logic [63:0] m_in [NB], m_out [NB], c [NB], p [NB], e_p [NB];
  logic [63:0] ad;
  logic [127:0] m_tag, t_in, t_clean, e_t;
  bit e_ok;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic void m_perm(input int nr);
    logic [4:0] v;
    for (int i = 12 - nr; i < 12; i++) begin
      m_x[2] ^= 64'((15 - i) * 16 + i);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{m_x[0][b], m_x[1][b], m_x[2][b], m_x[3][b], m_x[4][b]}];
        {m_x[0][b], m_x[1][b], m_x[2][b], m_x[3][b], m_x[4][b]} = v;
      end
      m_x[0] ^= ror(m_x[0], 19) ^ ror(m_x[0], 28);
      m_x[1] ^= ror(m_x[1], 61) ^ ror(m_x[1], 39);
      m_x[2] ^= ror(m_x[2], 1) ^ ror(m_x[2], 6);
      m_x[3] ^= ror(m_x[3], 10) ^ ror(m_x[3], 17);
      m_x[4] ^= ror(m_x[4], 7) ^ ror(m_x[4], 41);
    end
  endfunction

  // dec=0: m_in is plaintext, m_out ciphertext; dec=1: the reverse.
  function automatic void m_model(input bit dec);
    m_x = '{IV, key_i[127:64], key_i[63:0], nonce_i[127:64], nonce_i[63:0]};
    m_perm(12);
    m_x[3] ^= key_i[127:64];
    m_x[4] ^= key_i[63:0];
    m_x[0] ^= ad;
    m_perm(6);
    m_x[4] ^= 64'd1;
    for (int i = 0; i < NB; i++) begin
      m_out[i] = m_x[0] ^ m_in[i];
      m_x[0] = dec ? m_in[i] : m_out[i];
      if (i < NB - 1) m_perm(6);
    end
    m_x[1] ^= key_i[127:64];
    m_x[2] ^= key_i[63:0];
    m_perm(12);
    m_tag = {m_x[3], m_x[4]} ^ key_i;
  endfunction

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // mode 0 normal, 1 data_valid held high, 2 start pulsed in PERM_CT, 3 reset in FINAL cycle 5
  task automatic run(input int mode);
    int sz;
    base = pq.size();
    start_i = 1'b1;
    data_valid_i = (mode == 1);
    data_i = ad;
    step();
    start_i = 1'b0;
    chk("end_after_start", {127'd0, end_o}, 128'd0);
    chk("busy_after_start", {127'd0, busy_o}, 128'd1);
    repeat (12) step();
    data_valid_i = 1'b1;
    step();
    data_valid_i = (mode == 1);
    repeat (6) step();
    for (int i = 0; i < NB; i++) begin
      data_i = c[i];
      tag_i = t_in;
      data_valid_i = 1'b1;
      step();
      data_valid_i = (mode == 1);
      if (i < NB - 1)
        for (int k = 0; k < 6; k++) begin
          start_i = (mode == 2 && k == 2);
          step();
        end
      else if (mode == 3) begin
        repeat (4) step();
        sz = pq.size();
        resetb_i = 1'b0;
        #1;
        chk("rst_plain", {64'd0, plain_o}, 128'd0);
        chk("rst_pvalid", {127'd0, plain_valid_o}, 128'd0);
        chk("rst_tag", tag_o, 128'd0);
        chk("rst_tagok", {127'd0, tag_ok_o}, 128'd0);
        chk("rst_end", {127'd0, end_o}, 128'd0);
        chk("rst_busy", {127'd0, busy_o}, 128'd0);
        data_valid_i = 1'b0;
        step();
        resetb_i = 1'b1;
        repeat (3) step();
        chk("rst_no_pulse", 128'(pq.size()), 128'(sz));
      end else begin
        repeat (11) step();
        chk("end_v12", {127'd0, end_o}, 128'd0);
        step();
      end
    end
    data_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_msg();
    chk("n_plain", 128'(pq.size() - base), 128'(NB));
    for (int i = 0; i < NB; i++)
      chk($sformatf("plain%0d", i), {64'd0, (base + i < pq.size()) ? pq[base + i] : 64'hx}, {64'd0, e_p[i]});
    chk("tag", tag_o, e_t);
    chk("tag_ok", {127'd0, tag_ok_o}, {127'd0, e_ok});
    chk("end", {127'd0, end_o}, 128'd1);
    chk("busy_done", {127'd0, busy_o}, 128'd0);
  endtask

  initial begin
    repeat (3) step();
    chk("reset_plain", {64'd0, plain_o}, 128'd0);
    chk("reset_pvalid", {127'd0, plain_valid_o}, 128'd0);
    chk("reset_tag", tag_o, 128'd0);
    chk("reset_tagok", {127'd0, tag_ok_o}, 128'd0);
    chk("reset_end", {127'd0, end_o}, 128'd0);
    chk("reset_busy", {127'd0, busy_o}, 128'd0);
    resetb_i = 1'b1;
    step();

    key_i = 128'h8a55114d1cb6a9a2be263d4d7aecaaff;
    nonce_i = 128'h4ed0ec0b98c529b7c8cddf37bcd0284a;
    ad = 64'h4120746f20428000;
    for (int i = 0; i < NB; i++) p[i] = {$urandom, $urandom};
    m_in = p;
    m_model(1'b0);
    c = m_out;
    t_in = m_tag;
    t_clean = m_tag;
    e_p = p;
    e_t = m_tag;
    e_ok = TC;
    run(0);
    check_msg();

    c[1] ^= 64'd1;
    m_in = c;
    m_model(1'b1);
    e_p = m_out;
    e_t = m_tag;
    e_ok = TC && (m_tag == t_in);
    run(0);
    check_msg();
    chk("tamper_p2_bit0", {64'd0, pq[base + 1] ^ p[1]}, 128'd1);
    chk("tamper_p3_changed", {127'd0, pq[base + 2] !== p[2]}, 128'd1);
    chk("tamper_tag_changed", {127'd0, tag_o !== t_clean}, 128'd1);
    chk("tamper_tag_ok", {127'd0, tag_ok_o}, 128'd0);
    c[1] ^= 64'd1;

    e_p = p;
    e_t = t_clean;
    e_ok = TC;
    run(1);
    check_msg();
    run(2);
    check_msg();
    run(3);
    run(0);
    check_msg();

    key_i = {$urandom, $urandom, $urandom, $urandom};
    nonce_i = {$urandom, $urandom, $urandom, $urandom};
    ad = {$urandom, $urandom};
    for (int i = 0; i < NB; i++) p[i] = {$urandom, $urandom};
    m_in = p;
    m_model(1'b0);
    c = m_out;
    t_in = m_tag;
    e_p = p;
    e_t = m_tag;
    e_ok = TC;
    run(0);
    check_msg();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
